// File: rtl/switch_cond_pkg.sv
// Shared types and helpers for the switch conditioner.
// Holds the per-channel state encodings and the counter width helper.
package switch_cond_pkg;

    typedef enum logic {
        STABLE = 1'b0,
        PEND   = 1'b1
    } deb_state_t;

    typedef enum logic {
        DELAY = 1'b0,
        RATE  = 1'b1
    } rep_phase_t;

    // Bits needed to hold 0..max_val; never less than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One switch channel: 2-flop synchroniser, tick-based debounce FSM,
// edge pulses and auto-repeat step pulses.
// Ports:
//   clock, rst  : system clock, async active-high reset
//   raw         : asynchronous switch level
//   repeat_en   : auto-repeat enable (synchronous)
//   tick        : shared debounce tick strobe
//   level       : debounced level
//   rise, fall  : 1-cycle pulses on debounced edges
//   step        : rise or auto-repeat pulse
module debounce_channel
    import switch_cond_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = 20,
    parameter int REPEAT_DELAY   = 500,
    parameter int REPEAT_RATE    = 200
) (
    input  logic clock,
    input  logic rst,
    input  logic raw,
    input  logic repeat_en,
    input  logic tick,
    output logic level,
    output logic rise,
    output logic fall,
    output logic step
);

    localparam int DW = cnt_width(DEBOUNCE_TICKS);
    localparam int RW = cnt_width(imax(REPEAT_DELAY, REPEAT_RATE));

    localparam logic [DW-1:0] D_LAST     = DW'(DEBOUNCE_TICKS - 1);
    localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

    logic          s1;
    logic          s;
    deb_state_t    state;
    rep_phase_t    phase;
    logic [DW-1:0] dcnt;
    logic [RW-1:0] rcnt;
    logic          commit;
    logic          rep_active;
    logic          rep_hit;
    logic [RW-1:0] rep_last;

    always_comb begin
        commit     = (state == PEND) && (s != level) && tick
                     && (dcnt == D_LAST);
        rep_active = (state == STABLE) && level && repeat_en;
        rep_last   = (phase == DELAY) ? DELAY_LAST : RATE_LAST;
        rep_hit    = rep_active && tick && (rcnt == rep_last);
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s  <= 1'b0;
        end else begin
            s1 <= raw;
            s  <= s1;
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state <= STABLE;
            dcnt  <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= commit & s;
            fall <= commit & ~s;
            unique case (state)
                STABLE: begin
                    if (s != level) begin
                        state <= PEND;
                        dcnt  <= '0;
                    end
                end
                PEND: begin
                    if (s == level) begin
                        // Glitch: drop back without committing.
                        state <= STABLE;
                        dcnt  <= '0;
                    end else if (commit) begin
                        level <= s;
                        state <= STABLE;
                    end else if (tick) begin
                        dcnt <= dcnt + DW'(1);
                    end
                end
            endcase
        end
    end

    // The counter is idle (and the phase rearmed) whenever the hold is
    // broken, so any re-entry restarts the full initial delay.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            phase <= DELAY;
            rcnt  <= '0;
            step  <= 1'b0;
        end else begin
            step <= (commit & s) | rep_hit;
            if (!rep_active) begin
                rcnt  <= '0;
                phase <= DELAY;
            end else if (rep_hit) begin
                rcnt  <= '0;
                phase <= RATE;
            end else if (tick) begin
                rcnt <= rcnt + RW'(1);
            end
        end
    end

endmodule

// File: rtl/switch_conditioner.sv
// Conditions raw board switches: synchronise, debounce, edge and
// auto-repeat step pulses per channel, driven by a shared tick.
// Ports:
//   clock, rst  : system clock, async active-high reset
//   raw         : asynchronous switch levels [WIDTH]
//   repeat_en   : per-bit auto-repeat enable [WIDTH]
//   level       : debounced levels [WIDTH]
//   rise, fall  : 1-cycle edge pulses [WIDTH]
//   step        : rise or auto-repeat pulses [WIDTH]
//   tick        : 1-cycle debounce tick strobe
module switch_conditioner
    import switch_cond_pkg::*;
#(
    parameter int WIDTH          = 16,
    parameter int TICK_DIV       = 100000,
    parameter int DEBOUNCE_TICKS = 20,
    parameter int REPEAT_DELAY   = 500,
    parameter int REPEAT_RATE    = 200
) (
    input  logic             clock,
    input  logic             rst,
    input  logic [WIDTH-1:0] raw,
    input  logic [WIDTH-1:0] repeat_en,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] step,
    output logic             tick
);

    localparam int PW = cnt_width(TICK_DIV - 1);
    localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] pcnt;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            pcnt <= '0;
        end else if (pcnt == P_LAST) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + PW'(1);
        end
    end

    assign tick = (pcnt == P_LAST);

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_RATE    (REPEAT_RATE)
        ) u_ch (
            .clock     (clock),
            .rst       (rst),
            .raw       (raw[i]),
            .repeat_en (repeat_en[i]),
            .tick      (tick),
            .level     (level[i]),
            .rise      (rise[i]),
            .fall      (fall[i]),
            .step      (step[i])
        );
    end

endmodule
